// File: rtl/request_unit_if.sv
// Handshake bundle between the request unit, the fetch/decode front end and
// the instruction/data memory ports.
interface request_unit_if;
    logic        ihit;
    logic        dhit;
    logic        cu_dREN;
    logic        cu_dWEN;
    logic        cu_datomic;
    logic        cu_halt;
    logic [31:0] daddr;
    logic        snoop_inv;
    logic [31:0] snoop_addr;
    logic        imemREN;
    logic        dmemREN;
    logic        dmemWEN;
    logic        pc_en;
    logic        halt;
    logic        link_valid;
    logic        sc_success;

    modport master (
        input  ihit, dhit, cu_dREN, cu_dWEN, cu_datomic, cu_halt, daddr,
               snoop_inv, snoop_addr,
        output imemREN, dmemREN, dmemWEN, pc_en, halt, link_valid, sc_success
    );

    modport slave (
        output ihit, dhit, cu_dREN, cu_dWEN, cu_datomic, cu_halt, daddr,
               snoop_inv, snoop_addr,
        input  imemREN, dmemREN, dmemWEN, pc_en, halt, link_valid, sc_success
    );
endinterface

// File: rtl/request_unit.sv
// Sequences instruction fetch and data access for a single-issue core,
// including LL/SC link tracking with snoop invalidation.
module request_unit (
    input  logic           CLK,
    input  logic           nRST,
    request_unit_if.master ru
);
    typedef enum logic [1:0] {FETCH, DATA, HALTED} state_t;

    state_t      state, state_n;
    logic        dren_q, dren_n;
    logic        dwen_q, dwen_n;
    logic        halt_q, halt_n;
    logic        link_q, link_n;
    logic        sc_q, sc_n;
    logic        atomic_q, atomic_n;
    logic [31:0] addr_q, addr_n;
    logic [31:0] link_addr_q, link_addr_n;
    logic        pc_en;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= FETCH;
            dren_q      <= 1'b0;
            dwen_q      <= 1'b0;
            halt_q      <= 1'b0;
            link_q      <= 1'b0;
            sc_q        <= 1'b0;
            atomic_q    <= 1'b0;
            addr_q      <= '0;
            link_addr_q <= '0;
        end else begin
            state       <= state_n;
            dren_q      <= dren_n;
            dwen_q      <= dwen_n;
            halt_q      <= halt_n;
            link_q      <= link_n;
            sc_q        <= sc_n;
            atomic_q    <= atomic_n;
            addr_q      <= addr_n;
            link_addr_q <= link_addr_n;
        end
    end

    always_comb begin
        state_n     = state;
        dren_n      = dren_q;
        dwen_n      = dwen_q;
        halt_n      = halt_q;
        link_n      = link_q;
        sc_n        = sc_q;
        atomic_n    = atomic_q;
        addr_n      = addr_q;
        link_addr_n = link_addr_q;
        pc_en       = 1'b0;

        case (state)
            FETCH: begin
                if (ru.ihit) begin
                    if (ru.cu_halt) begin
                        state_n = HALTED;
                        halt_n  = 1'b1;
                    end else if (ru.cu_dWEN) begin
                        // A write wins over a simultaneous read request.
                        if (ru.cu_datomic) begin
                            if (link_q && (link_addr_q == ru.daddr)) begin
                                dwen_n   = 1'b1;
                                sc_n     = 1'b1;
                                link_n   = 1'b0;
                                addr_n   = ru.daddr;
                                atomic_n = 1'b1;
                                state_n  = DATA;
                            end else begin
                                sc_n  = 1'b0;
                                pc_en = 1'b1;
                            end
                        end else begin
                            dwen_n   = 1'b1;
                            addr_n   = ru.daddr;
                            atomic_n = 1'b0;
                            state_n  = DATA;
                            if (link_addr_q == ru.daddr)
                                link_n = 1'b0;
                        end
                    end else if (ru.cu_dREN) begin
                        dren_n   = 1'b1;
                        addr_n   = ru.daddr;
                        atomic_n = ru.cu_datomic;
                        state_n  = DATA;
                    end else begin
                        pc_en = 1'b1;
                    end
                end
            end
            DATA: begin
                if (ru.dhit) begin
                    pc_en   = 1'b1;
                    dren_n  = 1'b0;
                    dwen_n  = 1'b0;
                    state_n = FETCH;
                    if (dren_q && atomic_q) begin
                        link_n      = 1'b1;
                        link_addr_n = addr_q;
                    end
                end
            end
            HALTED: begin
            end
            default: state_n = FETCH;
        endcase

        // Snoop is checked against the link address as it will be after this
        // edge, so a snoop hitting an LL in flight cancels the new link.
        if (ru.snoop_inv && (ru.snoop_addr == link_addr_n))
            link_n = 1'b0;
    end

    assign ru.imemREN    = (state == FETCH);
    assign ru.dmemREN    = dren_q;
    assign ru.dmemWEN    = dwen_q;
    assign ru.pc_en      = pc_en;
    assign ru.halt       = halt_q;
    assign ru.link_valid = link_q;
    assign ru.sc_success = sc_q;
endmodule

// File: doc/request_unit.md
REQUEST_UNIT -- requirements
Module: request_unit

Interface
REQ-001 SHALL have port CLK, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port nRST, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port ihit, input, 1, instruction memory returned imemload this cycle.
REQ-004 SHALL have port dhit, input, 1, data memory completed the outstanding access this cycle.
REQ-005 SHALL have ports cu_dREN, cu_dWEN, cu_datomic, cu_halt, inputs, 1 each, decoded controls for the current imemload.
REQ-006 SHALL have port daddr, input, 32 (word_t), effective data address for the current instruction.
REQ-007 SHALL have ports snoop_inv, input, 1, and snoop_addr, input, 32, coherence invalidation of a word address.
REQ-008 SHALL have port imemREN, output, 1, instruction fetch request.
REQ-009 SHALL have ports dmemREN and dmemWEN, outputs, 1 each, registered data requests.
REQ-010 SHALL have port pc_en, output, 1, one-cycle retire pulse that advances the PC.
REQ-011 SHALL have port halt, output, 1, sticky processor halt.
REQ-012 SHALL have ports link_valid, output, 1, and sc_success, output, 1, where sc_success is the result of the last store-conditional.

Function
REQ-013 SHALL implement FSM states FETCH, DATA and HALTED.
REQ-014 SHALL assert imemREN=1 in FETCH, imemREN=0 in DATA and HALTED.
REQ-015 In FETCH with ihit=1 and cu_halt=1, SHALL enter HALTED next cycle, set halt=1, and not pulse pc_en.
REQ-016 In FETCH with ihit=1 and no cu_dREN/cu_dWEN, SHALL pulse pc_en=1 combinationally that cycle and remain in FETCH.
REQ-017 In FETCH with ihit=1 and cu_dREN=1, SHALL register dmemREN=1, capture daddr and cu_datomic, enter DATA, and hold pc_en=0.
REQ-018 In FETCH with ihit=1, cu_dWEN=1 and cu_datomic=0, SHALL register dmemWEN=1, capture daddr, enter DATA, and clear link_valid if the link address equals daddr.
REQ-019 In FETCH with ihit=1, cu_dWEN=1 and cu_datomic=1 (SC): if link_valid=1 and the link address equals daddr, SHALL register dmemWEN=1, set sc_success=1, clear link_valid and enter DATA; otherwise SHALL issue no write, set sc_success=0, pulse pc_en and remain in FETCH.
REQ-020 In DATA, SHALL hold dmemREN/dmemWEN unchanged until dhit=1; on dhit SHALL pulse pc_en, clear dmemREN/dmemWEN on the next edge and return to FETCH.
REQ-021 On dhit of a load with captured datomic=1 (LL), SHALL set link_valid=1 and the link address to the captured daddr.
REQ-022 SHALL ignore dhit in FETCH and HALTED, and ihit in DATA and HALTED.
REQ-023 When cu_dREN and cu_dWEN are both 1 on ihit, SHALL treat the instruction as a write and ignore cu_dREN.
REQ-024 SHALL clear link_valid on snoop_inv=1 with snoop_addr equal to the link address, in any state; on the same edge this takes priority over an LL set (net link_valid=0).
REQ-025 SHALL compare addresses as full 32-bit words with no masking.
REQ-026 HALTED SHALL be terminal until nRST; all request outputs SHALL be 0 and halt=1.
REQ-027 sc_success SHALL change only on an SC fetch and otherwise hold its value.

Reset
REQ-028 On nRST=0, asynchronously and independent of CLK, SHALL set state=FETCH, dmemREN=0, dmemWEN=0, halt=0, link_valid=0, sc_success=0 and link address=0; imemREN=1 after release.
REQ-029 Reset asserted in DATA SHALL abort the access with no pc_en pulse.

Verification
REQ-030 ALU op: ihit=1, no mem controls -> pc_en=1 same cycle, state FETCH, dmem requests 0.
REQ-031 Load with a 3-cycle memory wait: ihit with cu_dREN=1, daddr=0x100 -> dmemREN=1 for 3 cycles, imemREN=0, pc_en pulses on the dhit cycle only, dmemREN=0 on the next cycle.
REQ-032 LL/SC pair: LL at 0x200 then SC at 0x200 -> link_valid=1 after LL, dmemWEN issued, sc_success=1, link_valid=0.
REQ-033 SC fail: LL at 0x200, then snoop_inv with snoop_addr=0x200, then SC at 0x200 -> no dmemWEN, sc_success=0, pc_en pulses on ihit.
REQ-034 Halt: ihit with cu_halt=1 -> halt=1 next cycle, imemREN=0 thereafter, ihit/dhit ignored; nRST low -> halt=0.
REQ-035 Async reset mid-DATA: drop nRST between edges -> dmemREN=0 immediately, no pc_en pulse, FETCH after release.
